jump_return_stack: RTL and testbench

JUMP_RETURN_STACK -- requirements
Module: jump_return_stack

---
 rtl/jump_return_stack_pkg.sv | 24 ++
 rtl/ras_lifo.sv | 62 ++++++
 rtl/jump_return_stack.sv | 99 +++++++++
 tb/tb_jump_return_stack.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_return_stack_pkg.sv
// Shared definitions for the jump/return stack.
// Command encodings and default widths.
package jump_return_stack_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic [1:0] {
    CTL_NONE = 2'd0,
    CTL_CALL = 2'd1,
    CTL_JUMP = 2'd2,
    CTL_RET  = 2'd3
  } stack_ctl_e;

  typedef struct packed {
    logic take;
    logic push;
    logic pop;
    logic sel_top;
    logic ovf_set;
    logic unf_set;
  } ctl_dec_t;

endpackage

// File: rtl/ras_lifo.sv
// Return-address LIFO: storage, write pointer and depth.
// Storage is never reset; only pointer and depth are.
module ras_lifo
  import jump_return_stack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WRAP   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        push_data,
  output logic [ADDR_W-1:0]        top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     top_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full    = (depth == DW'(DEPTH));
  assign empty   = (depth == '0);
  // When full, wr_ptr points at the oldest entry, so a
  // wrapping push overwrites exactly that one.
  assign wr_en   = push && (!full || (WRAP != 0));
  assign rd_en   = pop && !empty;
  assign top_ptr = wr_ptr - PW'(1);
  assign top     = mem[top_ptr];

  // Storage write; deliberately without reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      depth  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (!full) begin
        depth <= depth + DW'(1);
      end
    end else if (rd_en) begin
      wr_ptr <= wr_ptr - PW'(1);
      depth  <= depth - DW'(1);
    end
  end

endmodule

// File: rtl/jump_return_stack.sv
// Jump/return stack: command decode, next-PC mux,
// sticky overflow/underflow flags.
module jump_return_stack
  import jump_return_stack_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WRAP   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             stack_ctl,
  input  logic                   ctl_valid,
  input  logic [ADDR_W-1:0]      address_in,
  input  logic [ADDR_W-1:0]      return_addr_in,
  input  logic                   err_clr,
  output logic [ADDR_W-1:0]      address,
  output logic                   take_jump,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   overflow,
  output logic                   underflow
);

  ctl_dec_t          dec;
  logic [ADDR_W-1:0] top;
  logic              full;
  logic              empty;

  ras_lifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .WRAP   (WRAP)
  ) u_lifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (dec.push),
    .pop       (dec.pop),
    .push_data (return_addr_in),
    .top       (top),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

  // Decode the qualified command against stack state.
  always_comb begin
    dec = '0;
    if (ctl_valid) begin
      unique case (stack_ctl_e'(stack_ctl))
        CTL_CALL: begin
          dec.take    = 1'b1;
          dec.push    = 1'b1;
          dec.ovf_set = full;
        end
        CTL_JUMP: begin
          dec.take = 1'b1;
        end
        CTL_RET: begin
          if (empty) begin
            dec.unf_set = 1'b1;
          end else begin
            dec.take    = 1'b1;
            dec.pop     = 1'b1;
            dec.sel_top = 1'b1;
          end
        end
        default: begin
          dec = '0;
        end
      endcase
    end
  end

  assign address   = dec.sel_top ? top : address_in;
  assign take_jump = dec.take;

  // Sticky overflow; a new error beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (dec.ovf_set) begin
      overflow <= 1'b1;
    end else if (err_clr) begin
      overflow <= 1'b0;
    end
  end

  // Sticky underflow; a new error beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (dec.unf_set) begin
      underflow <= 1'b1;
    end else if (err_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jump_return_stack.sv
// Scoreboard bench for jump_return_stack.
// Three instances: 8/no-wrap, 4/no-wrap, 4/wrap.
module tb_jump_return_stack;
  import jump_return_stack_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] stack_ctl;
  logic       ctl_valid;
  logic [7:0] address_in;
  logic [7:0] return_addr_in;
  logic       err_clr;

  logic [7:0] a0, a1, a2;
  logic       t0, t1, t2;
  logic [3:0] d0;
  logic [2:0] d1, d2;
  logic       o0, o1, o2;
  logic       u0, u1, u2;

  int checks = 0;
  int errors = 0;
  bit busy   = 1'b0;

  typedef struct {
    int         sel;
    string      name;
    logic [7:0] addr;
    logic       tj;
    int         dep;
    logic       ov;
    logic       un;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  jump_return_stack #(.ADDR_W(8), .DEPTH(8), .WRAP(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .stack_ctl(stack_ctl),
    .ctl_valid(ctl_valid), .address_in(address_in),
    .return_addr_in(return_addr_in), .err_clr(err_clr),
    .address(a0), .take_jump(t0), .depth(d0),
    .overflow(o0), .underflow(u0));

  jump_return_stack #(.ADDR_W(8), .DEPTH(4), .WRAP(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .stack_ctl(stack_ctl),
    .ctl_valid(ctl_valid), .address_in(address_in),
    .return_addr_in(return_addr_in), .err_clr(err_clr),
    .address(a1), .take_jump(t1), .depth(d1),
    .overflow(o1), .underflow(u1));

  jump_return_stack #(.ADDR_W(8), .DEPTH(4), .WRAP(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .stack_ctl(stack_ctl),
    .ctl_valid(ctl_valid), .address_in(address_in),
    .return_addr_in(return_addr_in), .err_clr(err_clr),
    .address(a2), .take_jump(t2), .depth(d2),
    .overflow(o2), .underflow(u2));

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  // Monitor: combinational outputs mid-low-phase,
  // registered state just after the following edge.
  initial begin
    exp_t       e;
    logic [7:0] ca;
    logic       ct;
    int         cd;
    logic       co;
    logic       cu;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        busy = 1'b1;
        e = q.pop_front();
        case (e.sel)
          0:       begin ca = a0; ct = t0; end
          1:       begin ca = a1; ct = t1; end
          default: begin ca = a2; ct = t2; end
        endcase
        @(posedge clk);
        #1;
        case (e.sel)
          0:       begin cd = int'(d0); co = o0; cu = u0; end
          1:       begin cd = int'(d1); co = o1; cu = u1; end
          default: begin cd = int'(d2); co = o2; cu = u2; end
        endcase
        chk({e.name, ".addr"}, int'(ca), int'(e.addr));
        chk({e.name, ".tj"}, int'(ct), int'(e.tj));
        chk({e.name, ".depth"}, cd, e.dep);
        chk({e.name, ".ovf"}, int'(co), int'(e.ov));
        chk({e.name, ".unf"}, int'(cu), int'(e.un));
        busy = 1'b0;
      end
    end
  end

  task automatic step(
    input int sel, input string nm,
    input logic v, input logic [1:0] c,
    input logic [7:0] ain, input logic [7:0] rin,
    input logic clr,
    input logic [7:0] ea, input logic et,
    input int ed, input logic eo, input logic eu);
    exp_t e;
    @(negedge clk);
    ctl_valid      = v;
    stack_ctl      = c;
    address_in     = ain;
    return_addr_in = rin;
    err_clr        = clr;
    e.sel  = sel;
    e.name = nm;
    e.addr = ea;
    e.tj   = et;
    e.dep  = ed;
    e.ov   = eo;
    e.un   = eu;
    q.push_back(e);
  endtask

  task automatic drain;
    int n;
    @(negedge clk);
    ctl_valid = 1'b0;
    stack_ctl = CTL_NONE;
    err_clr   = 1'b0;
    n = 0;
    while ((q.size() != 0 || busy) && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q.size() != 0 || busy) begin
      chk("drain_timeout", 1, 0);
      q.delete();
    end
  endtask

  task automatic do_reset;
    drain();
    rst_n = 1'b0;
    #1;
    chk("rst.depth", int'(d0), 0);
    chk("rst.ovf", int'(o0), 0);
    chk("rst.unf", int'(u0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    ctl_valid      = 1'b0;
    stack_ctl      = CTL_NONE;
    address_in     = 8'h00;
    return_addr_in = 8'h00;
    err_clr        = 1'b0;

    // Case 1: nested call/return on the 8-deep stack
    do_reset();
    step(0, "c1_call1", 1, CTL_CALL, 8'h40, 8'h11, 0,
         8'h40, 1, 1, 0, 0);
    step(0, "c1_call2", 1, CTL_CALL, 8'h80, 8'h41, 0,
         8'h80, 1, 2, 0, 0);
    step(0, "c1_ret1", 1, CTL_RET, 8'h00, 8'h00, 0,
         8'h41, 1, 1, 0, 0);
    step(0, "c1_ret2", 1, CTL_RET, 8'h00, 8'h00, 0,
         8'h11, 1, 0, 0, 0);
    step(0, "c1_none", 1, CTL_NONE, 8'h55, 8'h00, 0,
         8'h55, 0, 0, 0, 0);

    // Case 2: underflow, clear, set-wins
    step(0, "c2_ret_empty", 1, CTL_RET, 8'h22, 8'h00, 0,
         8'h22, 0, 0, 0, 1);
    step(0, "c2_hold", 0, CTL_NONE, 8'h23, 8'h00, 0,
         8'h23, 0, 0, 0, 1);
    step(0, "c2_clr", 0, CTL_NONE, 8'h24, 8'h00, 1,
         8'h24, 0, 0, 0, 0);
    step(0, "c2_setwins", 1, CTL_RET, 8'h25, 8'h00, 1,
         8'h25, 0, 0, 0, 1);
    step(0, "c2_clr2", 0, CTL_RET, 8'h26, 8'h00, 1,
         8'h26, 0, 0, 0, 0);

    // Case 6: unqualified RET and JUMP leave the stack alone
    step(0, "c6_call1", 1, CTL_CALL, 8'h10, 8'hA1, 0,
         8'h10, 1, 1, 0, 0);
    step(0, "c6_call2", 1, CTL_CALL, 8'h20, 8'hA2, 0,
         8'h20, 1, 2, 0, 0);
    step(0, "c6_noval", 0, CTL_RET, 8'h77, 8'h00, 0,
         8'h77, 0, 2, 0, 0);
    step(0, "c6_jump", 1, CTL_JUMP, 8'h99, 8'h00, 0,
         8'h99, 1, 2, 0, 0);
    step(0, "c6_ret", 1, CTL_RET, 8'h00, 8'h00, 0,
         8'hA2, 1, 1, 0, 0);

    // Case 3: 4-deep, no wrap, five calls
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1, "c3_call", 1, CTL_CALL, 8'(8'h60 + i),
           8'(i), 0, 8'(8'h60 + i), 1,
           (i < 4) ? i : 4, (i == 5), 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, "c3_ret", 1, CTL_RET, 8'hF0, 8'h00, 0,
           8'(4 - i), 1, 3 - i, 1, 0);
    end
    step(1, "c3_ret_empty", 1, CTL_RET, 8'hF1, 8'h00, 0,
         8'hF1, 0, 0, 1, 1);

    // Case 4: 4-deep, wrap, five calls
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(2, "c4_call", 1, CTL_CALL, 8'(8'h70 + i),
           8'(i), 0, 8'(8'h70 + i), 1,
           (i < 4) ? i : 4, (i == 5), 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(2, "c4_ret", 1, CTL_RET, 8'hE0, 8'h00, 0,
           8'(5 - i), 1, 3 - i, 1, 0);
    end

    // Case 5: asynchronous reset mid-cycle
    do_reset();
    step(0, "c5_call1", 1, CTL_CALL, 8'h30, 8'hB1, 0,
         8'h30, 1, 1, 0, 0);
    step(0, "c5_call2", 1, CTL_CALL, 8'h31, 8'hB2, 0,
         8'h31, 1, 2, 0, 0);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    chk("c5_async.depth", int'(d0), 0);
    ctl_valid  = 1'b1;
    stack_ctl  = CTL_RET;
    address_in = 8'h33;
    #1;
    chk("c5_inrst_ret.addr", int'(a0), 8'h33);
    chk("c5_inrst_ret.tj", int'(t0), 0);
    stack_ctl  = CTL_CALL;
    address_in = 8'h34;
    #1;
    chk("c5_inrst_call.addr", int'(a0), 8'h34);
    chk("c5_inrst_call.tj", int'(t0), 1);
    ctl_valid = 1'b0;
    stack_ctl = CTL_NONE;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, "c5_ret_after", 1, CTL_RET, 8'h2C, 8'h00, 0,
         8'h2C, 0, 0, 0, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
